md_unit: RTL and testbench

- Iterative multiply/divide unit with the HI/LO register pair for the MIPS datapath.
- Sits directly upstream of the ALU: it takes the same A/B operand buses from the register file.
- Its HI/LO outputs drive the ALU A-input mux for MFHI/MFLO, where the ALU passes A through on NOP.
- It is the only multi-cycle EX-stage resource; control stalls issue while busy is high.

---
 rtl/md_unit.sv | 129 ++++++++++++
 tb/tb_md_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Iterative multiply/divide unit holding the HI/LO pair: radix-2 shift-add multiply and
// restoring divide, one bit per clock, with the sign fix-up applied in a final cycle.
module md_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       MDOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;   // multiply: {partial, multiplier}; divide: {remainder, quotient}
    logic [WIDTH-1:0]     opb;   // |multiplicand| or |divisor|
    logic                 sa, sb, is_div, dz;

    logic                 md_req, sgn;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       madd, rsh, dsub;
    logic [2*WIDTH-1:0]   mul_nxt, div_nxt, prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        md_req    = start && !MDOp[2];
        case (state)
            IDLE:    if (md_req) state_nxt = CALC;
            CALC:    if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sgn   = ~MDOp[0];
        abs_a = (sgn && A[WIDTH-1]) ? -A : A;
        abs_b = (sgn && B[WIDTH-1]) ? -B : B;

        madd    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        mul_nxt = {madd, acc[WIDTH-1:1]};

        // Shift the next dividend bit into the remainder and keep the difference if it fits.
        rsh     = acc[2*WIDTH-1:WIDTH-1];
        dsub    = rsh - {1'b0, opb};
        div_nxt = dsub[WIDTH] ? {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                              : {dsub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        prod_fix = (sa ^ sb) ? -acc : acc;
        // A zero divisor leaves the remainder equal to |A|, so only the quotient is forced.
        quo_fix  = dz ? '1 : ((sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        rem_fix  = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            is_div <= 1'b0;
            dz     <= 1'b0;
            done   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (MDOp == 3'b100) HI <= A;
                        if (MDOp == 3'b101) LO <= A;
                        if (md_req) begin
                            cnt    <= '0;
                            sa     <= sgn & A[WIDTH-1];
                            sb     <= sgn & B[WIDTH-1];
                            is_div <= MDOp[1];
                            dz     <= MDOp[1] && (B == '0);
                            if (MDOp[1]) begin
                                acc <= {{WIDTH{1'b0}}, abs_a};
                                opb <= abs_b;
                            end else begin
                                acc <= {{WIDTH{1'b0}}, abs_b};
                                opb <= abs_a;
                            end
                        end
                    end
                end
                CALC: begin
                    acc <= is_div ? div_nxt : mul_nxt;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (is_div) begin
                        HI <= rem_fix;
                        LO <= quo_fix;
                    end else begin
                        {HI, LO} <= prod_fix;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed vector table, multi-cycle corner sequences and a random
// phase checked against an arithmetic model of HI/LO.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  MDOp;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] HI, LO;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    md_unit dut (
        .clk(clk), .rst(rst), .start(start), .MDOp(MDOp), .A(A), .B(B),
        .busy(busy), .done(done), .HI(HI), .LO(LO), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint q, r;
        logic [63:0] p;
        case (op)
            3'd0: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); {model_hi, model_lo} = p; end
            3'd1: begin p = {32'h0, a} * {32'h0, b}; {model_hi, model_lo} = p; end
            3'd2: begin
                if (b == 0) begin model_hi = a; model_lo = '1; end
                else begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    model_lo = q[31:0];
                    model_hi = r[31:0];
                end
            end
            3'd3: begin
                if (b == 0) begin model_hi = a; model_lo = '1; end
                else begin model_lo = a / b; model_hi = a % b; end
            end
            3'd4: model_hi = a;
            3'd5: model_lo = a;
            default: ;
        endcase
    endtask

    // Drive a request for one edge, then scramble the operands to prove they are latched.
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; MDOp = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom; MDOp = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_done(input int exp_busy, input logic [31:0] ehi, input logic [31:0] elo,
                             input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 64'(n), 64'(exp_busy));
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " HI"}, 64'(HI), 64'(ehi));
        check({tag, " LO"}, 64'(LO), 64'(elo));
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input string tag);
        @(negedge clk);
        launch(op, a, b);
        wait_done(33, ehi, elo, tag);
        model_hi = ehi;
        model_lo = elo;
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(done), 64'd0);
    endtask

    // Single-cycle requests: MTHI/MTLO and the reserved codes.
    task automatic quick_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input string tag);
        @(negedge clk);
        start = 1'b1; MDOp = op; A = a; B = b;
        model_apply(op, a, b);
        @(negedge clk);
        start = 1'b0;
        check({tag, " HI"}, 64'(HI), 64'(model_hi));
        check({tag, " LO"}, 64'(LO), 64'(model_lo));
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[5]  = '{3'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[6]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[7]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{3'd2, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[9]  = '{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[10] = '{3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        vecs[11] = '{3'd2, 32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF};

        rst = 1'b1; start = 1'b0; MDOp = '0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        check("reset HI", 64'(HI), 64'd0);
        check("reset LO", 64'(LO), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

        // MTHI then MTLO on consecutive edges.
        @(negedge clk);
        start = 1'b1; MDOp = 3'b100; A = 32'h12345678;
        @(negedge clk);
        check("mthi HI", 64'(HI), 64'h12345678);
        check("mthi LO", 64'(LO), 64'(model_lo));
        check("mthi busy", 64'(busy), 64'd0);
        MDOp = 3'b101; A = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        check("mtlo LO", 64'(LO), 64'h9ABCDEF0);
        check("mtlo HI", 64'(HI), 64'h12345678);
        check("mtlo done", 64'(done), 64'd0);
        model_hi = 32'h12345678;
        model_lo = 32'h9ABCDEF0;

        quick_op(3'b110, 32'hAAAA5555, 32'h3, "nop110");
        quick_op(3'b111, 32'h5555AAAA, 32'h0, "nop111");

        // Back-to-back: second request issued in the cycle where done is high.
        @(negedge clk);
        launch(3'd1, 32'd6, 32'd7);
        wait_done(33, 32'd0, 32'd42, "b2b_first");
        launch(3'd3, 32'd100, 32'd7);
        wait_done(33, 32'd2, 32'd14, "b2b_second");
        @(negedge clk);
        check("b2b done_pulse", 64'(done), 64'd0);

        // A request during CALC must be ignored.
        @(negedge clk);
        launch(3'd1, 32'd6, 32'd7);
        repeat (9) @(negedge clk);
        check("restart HI_stable", 64'(HI), 64'd2);
        start = 1'b1; MDOp = 3'd3; A = 32'd1000; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(23, 32'd0, 32'd42, "restart");
        model_hi = 32'd0;
        model_lo = 32'd42;

        // Asynchronous reset in the middle of a divide.
        quick_op(3'b100, 32'hDEADBEEF, 32'h0, "mthi_pre_rst");
        @(negedge clk);
        launch(3'd3, 32'd1000, 32'd7);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst HI", 64'(HI), 64'd0);
        check("midrst LO", 64'(LO), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_hi = '0;
        model_lo = '0;
        run_op(3'd1, 32'd3, 32'd4, 32'd0, 32'd12, "post_rst");

        // Random operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 9) == 0) ? 32'h80000000 : 32'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 32'h0 :
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
            if (!op[2]) begin
                model_apply(op, a, b);
                run_op(op, a, b, model_hi, model_lo, $sformatf("rand%0d_op%0d", i, op));
            end else begin
                quick_op(op, a, b, $sformatf("rand%0d_op%0d", i, op));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
